// File: rtl/bc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : bc_datapath
//  Purpose  : Register/bus datapath of the basic computer. It holds AR, PC, DR,
//             AC, IR, TR and the E flag, plus the common bus and the ALU. It is
//             driven by the instruction controller's bus-select code and its
//             control-signal vector, and it drives a synchronous memory port.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             BUS_SEL           - common-bus source select
//             CTRL              - flattened 3-bit control elements
//             mem_rdata         - memory read data (bus source 110)
//             mem_addr/wdata/we - memory port (addr = AR, data = bus)
//             IR, AC_OUT, E_OUT - register observation
//             CO, OVF           - registered carry/overflow of the last ADD
//             Z, N              - zero/negative flags of the current AC
//  Revision : 1.0 - initial release
// ============================================================================
module bc_datapath #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 12,
    parameter int CTRL_LNGTH = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              BUS_SEL,
    input  logic [3*CTRL_LNGTH-1:0] CTRL,
    input  logic [WIDTH-1:0]        mem_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WIDTH-1:0]        mem_wdata,
    output logic                    mem_we,
    output logic [WIDTH-1:0]        IR,
    output logic [WIDTH-1:0]        AC_OUT,
    output logic                    CO,
    output logic                    OVF,
    output logic                    Z,
    output logic                    N,
    output logic                    E_OUT
);

    // Control element indices (bit 0 of each element)
    localparam int c_AR_LD  = 0;
    localparam int c_AR_INC = 1;
    localparam int c_AR_CLR = 2;
    localparam int c_PC_LD  = 3;
    localparam int c_PC_INC = 4;
    localparam int c_PC_CLR = 5;
    localparam int c_DR_LD  = 6;
    localparam int c_DR_INC = 7;
    localparam int c_DR_CLR = 8;
    localparam int c_AC_LD  = 9;
    localparam int c_AC_INC = 10;
    localparam int c_AC_CLR = 11;
    localparam int c_IR_LD  = 12;
    localparam int c_TR_LD  = 13;
    localparam int c_TR_INC = 14;
    localparam int c_TR_CLR = 15;
    localparam int c_MEM_WR = 16;
    localparam int c_RSVD   = 17;
    localparam int c_E_CMP  = 18;
    localparam int c_E_CLR  = 19;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_AND = 3'b001;
    localparam logic [2:0] c_OP_TRF = 3'b010;
    localparam logic [2:0] c_OP_CMA = 3'b011;
    localparam logic [2:0] c_OP_CIL = 3'b100;
    localparam logic [2:0] c_OP_CIR = 3'b101;

    logic [ADDR_W-1:0] r_ar;
    logic [ADDR_W-1:0] r_pc;
    logic [WIDTH-1:0]  r_dr;
    logic [WIDTH-1:0]  r_ac;
    logic [WIDTH-1:0]  r_ir;
    logic [WIDTH-1:0]  r_tr;
    logic              r_e;
    logic              r_co;
    logic              r_ovf;

    // ------------------------------------------------------------------
    // Control decode: single-bit elements use bit 0 only; the last element
    // carries the 3-bit ALU op. Bits 1..2 of the single-bit elements and the
    // reserved element are intentionally ignored.
    // ------------------------------------------------------------------
    logic [CTRL_LNGTH-2:0]         w_en;
    logic [2*(CTRL_LNGTH-1)-1:0]   w_unused_hi;
    logic [2:0]                    w_op;
    logic                          w_unused_ctrl;

    for (genvar gi = 0; gi < CTRL_LNGTH - 1; gi++) begin : g_ctrl_bit0
        assign w_en[gi]               = CTRL[3*gi];
        assign w_unused_hi[2*gi +: 2] = CTRL[3*gi+1 +: 2];
    end

    assign w_op          = CTRL[3*(CTRL_LNGTH-1) +: 3];
    assign w_unused_ctrl = ^{w_unused_hi, w_en[c_RSVD]};

    // ------------------------------------------------------------------
    // Common bus
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bus;

    always_comb begin
        w_bus = '0;
        case (BUS_SEL)
            3'b000:  w_bus = '0;
            3'b001:  w_bus = {{(WIDTH-ADDR_W){1'b0}}, r_ar};
            3'b010:  w_bus = {{(WIDTH-ADDR_W){1'b0}}, r_pc};
            3'b011:  w_bus = r_dr;
            3'b100:  w_bus = r_ir;
            3'b101:  w_bus = r_ac;
            3'b110:  w_bus = mem_rdata;
            default: w_bus = r_tr;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_e;
    logic             w_alu_e_upd;

    assign w_sum     = {1'b0, r_ac} + {1'b0, r_dr};
    // Signed overflow: operands agree in sign but the result does not
    assign w_alu_ovf = (r_ac[WIDTH-1] == r_dr[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_ac[WIDTH-1]);

    always_comb begin
        w_alu_res = r_ac;
        w_alu_e   = r_e;
        case (w_op)
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_e   = w_sum[WIDTH];
            end
            c_OP_AND: w_alu_res = r_ac & r_dr;
            c_OP_TRF: w_alu_res = r_dr;
            c_OP_CMA: w_alu_res = ~r_ac;
            c_OP_CIL: begin
                w_alu_res = {r_ac[WIDTH-2:0], r_e};
                w_alu_e   = r_ac[WIDTH-1];
            end
            c_OP_CIR: begin
                w_alu_res = {r_e, r_ac[WIDTH-1:1]};
                w_alu_e   = r_ac[0];
            end
            default:  w_alu_res = r_ac;   // reserved / IDLE hold AC
        endcase
    end

    // E follows the ALU only for ADD and the circulates, and only when the
    // AC load element is asserted.
    assign w_alu_e_upd = w_en[c_AC_LD] &&
                         ((w_op == c_OP_ADD) || (w_op == c_OP_CIL) || (w_op == c_OP_CIR));

    // ------------------------------------------------------------------
    // Registers: every update uses pre-edge values; clr > load > inc.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar  <= '0;
            r_pc  <= '0;
            r_dr  <= '0;
            r_ac  <= '0;
            r_ir  <= '0;
            r_tr  <= '0;
            r_e   <= 1'b0;
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_en[c_AR_CLR])      r_ar <= '0;
            else if (w_en[c_AR_LD])  r_ar <= w_bus[ADDR_W-1:0];
            else if (w_en[c_AR_INC]) r_ar <= r_ar + ADDR_W'(1);

            if (w_en[c_PC_CLR])      r_pc <= '0;
            else if (w_en[c_PC_LD])  r_pc <= w_bus[ADDR_W-1:0];
            else if (w_en[c_PC_INC]) r_pc <= r_pc + ADDR_W'(1);

            if (w_en[c_DR_CLR])      r_dr <= '0;
            else if (w_en[c_DR_LD])  r_dr <= w_bus;
            else if (w_en[c_DR_INC]) r_dr <= r_dr + WIDTH'(1);

            if (w_en[c_AC_CLR])      r_ac <= '0;
            else if (w_en[c_AC_LD])  r_ac <= w_alu_res;
            else if (w_en[c_AC_INC]) r_ac <= r_ac + WIDTH'(1);

            if (w_en[c_IR_LD])       r_ir <= w_bus;

            if (w_en[c_TR_CLR])      r_tr <= '0;
            else if (w_en[c_TR_LD])  r_tr <= w_bus;
            else if (w_en[c_TR_INC]) r_tr <= r_tr + WIDTH'(1);

            // Carry/overflow are captured whenever an ADD is requested on AC
            if (w_en[c_AC_LD] && (w_op == c_OP_ADD)) begin
                r_co  <= w_sum[WIDTH];
                r_ovf <= w_alu_ovf;
            end

            if (w_en[c_E_CLR])       r_e <= 1'b0;
            else if (w_en[c_E_CMP])  r_e <= ~r_e;
            else if (w_alu_e_upd)    r_e <= w_alu_e;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr  = r_ar;
    assign mem_wdata = w_bus;
    assign mem_we    = w_en[c_MEM_WR] & rst_n;   // no write while in reset
    assign IR        = r_ir;
    assign AC_OUT    = r_ac;
    assign CO        = r_co;
    assign OVF       = r_ovf;
    assign Z         = (r_ac == '0);
    assign N         = r_ac[WIDTH-1];
    assign E_OUT     = r_e;

endmodule
`default_nettype wire

// File: tb/tb_bc_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bc_datapath
//  Purpose  : Self-checking bench for bc_datapath: directed scenarios plus
//             randomized control vectors compared with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bc_datapath;

    localparam int W  = 16;
    localparam int AW = 12;
    localparam int CL = 21;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      BUS_SEL = 3'b000;
    logic [3*CL-1:0] CTRL;
    logic [W-1:0]    mem_rdata = '0;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic            mem_we;
    logic [W-1:0]    IR;
    logic [W-1:0]    AC_OUT;
    logic            CO, OVF, Z, N, E_OUT;

    bc_datapath #(.WIDTH(W), .ADDR_W(AW), .CTRL_LNGTH(CL)) dut (
        .clk(clk), .rst_n(rst_n), .BUS_SEL(BUS_SEL), .CTRL(CTRL),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .IR(IR), .AC_OUT(AC_OUT), .CO(CO), .OVF(OVF),
        .Z(Z), .N(N), .E_OUT(E_OUT)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [11:0] m_ar, m_pc;
    logic [15:0] m_dr, m_ac, m_ir, m_tr;
    logic        m_e, m_co, m_ovf;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] bm(input int i);
        logic [19:0] v;
        v = 20'd1 << i;
        return v;
    endfunction

    // Element i enable goes to bit 3i; the other two bits get junk.
    function automatic logic [3*CL-1:0] mk_ctrl(input logic [19:0] en, input logic [2:0] op);
        logic [3*CL-1:0] c;
        c = '0;
        for (int i = 0; i < 20; i++) begin
            c[3*i]   = en[i];
            c[3*i+1] = 1'($urandom);
            c[3*i+2] = 1'($urandom);
        end
        c[60 +: 3] = op;
        return c;
    endfunction

    function automatic logic [15:0] model_bus(input logic [2:0] sel, input logic [15:0] rd);
        case (sel)
            3'd0:    return 16'h0000;
            3'd1:    return {4'h0, m_ar};
            3'd2:    return {4'h0, m_pc};
            3'd3:    return m_dr;
            3'd4:    return m_ir;
            3'd5:    return m_ac;
            3'd6:    return rd;
            default: return m_tr;
        endcase
    endfunction

    task automatic model_reset();
        m_ar = '0; m_pc = '0; m_dr = '0; m_ac = '0; m_ir = '0; m_tr = '0;
        m_e = 1'b0; m_co = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_clock(input logic [2:0] sel, input logic [19:0] en,
                               input logic [2:0] op, input logic [15:0] rd);
        logic [15:0] b, res, n_ac;
        logic [16:0] wide;
        logic        e_alu, n_e, n_co, n_ovf;
        int          sa, sb, s;
        b     = model_bus(sel, rd);
        res   = m_ac;
        e_alu = m_e;
        sa    = $signed(m_ac);
        sb    = $signed(m_dr);
        s     = sa + sb;
        case (op)
            3'd0: begin
                wide  = 17'(m_ac) + 17'(m_dr);
                res   = wide[15:0];
                e_alu = wide[16];
            end
            3'd1: res = m_ac & m_dr;
            3'd2: res = m_dr;
            3'd3: res = ~m_ac;
            3'd4: begin
                wide  = {m_ac, m_e};            // rotate left through E
                res   = wide[15:0];
                e_alu = wide[16];
            end
            3'd5: begin
                wide  = {m_ac[0], m_e, m_ac[15:1]}; // rotate right through E
                res   = wide[15:0];
                e_alu = wide[16];
            end
            default: res = m_ac;
        endcase
        n_ac  = en[11] ? 16'h0 : en[9] ? res : en[10] ? m_ac + 16'd1 : m_ac;
        n_co  = m_co;
        n_ovf = m_ovf;
        if (en[9] && op == 3'd0) begin
            n_co  = e_alu;
            n_ovf = (s > 32767) || (s < -32768);
        end
        n_e = m_e;
        if (en[19])      n_e = 1'b0;
        else if (en[18]) n_e = ~m_e;
        else if (en[9] && (op == 3'd0 || op == 3'd4 || op == 3'd5)) n_e = e_alu;

        m_ar  = en[2]  ? 12'h0 : en[0]  ? b[11:0] : en[1]  ? m_ar + 12'd1 : m_ar;
        m_pc  = en[5]  ? 12'h0 : en[3]  ? b[11:0] : en[4]  ? m_pc + 12'd1 : m_pc;
        m_dr  = en[8]  ? 16'h0 : en[6]  ? b       : en[7]  ? m_dr + 16'd1 : m_dr;
        m_tr  = en[15] ? 16'h0 : en[13] ? b       : en[14] ? m_tr + 16'd1 : m_tr;
        m_ir  = en[12] ? b : m_ir;
        m_ac  = n_ac;
        m_e   = n_e;
        m_co  = n_co;
        m_ovf = n_ovf;
    endtask

    task automatic check_regs();
        chk_eq("ir",   IR,       m_ir);
        chk_eq("ac",   AC_OUT,   m_ac);
        chk_eq("ar",   mem_addr, m_ar);
        chk_eq("co",   CO,       m_co);
        chk_eq("ovf",  OVF,      m_ovf);
        chk_eq("e",    E_OUT,    m_e);
        chk_eq("z",    Z,        m_ac == 16'h0);
        chk_eq("n",    N,        m_ac[15]);
    endtask

    task automatic go_idle();
        BUS_SEL = 3'd0;
        CTRL    = mk_ctrl(20'h0, 3'b111);
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic apply(input logic [2:0] sel, input logic [19:0] en,
                         input logic [2:0] op, input logic [15:0] rd);
        BUS_SEL   = sel;
        CTRL      = mk_ctrl(en, op);
        mem_rdata = rd;
        #2;
        chk_eq("wdata", mem_wdata, model_bus(sel, rd));
        chk_eq("we",    mem_we,    en[16]);
        chk_eq("addr",  mem_addr,  m_ar);
        model_clock(sel, en, op, rd);
        @(posedge clk);
        #1;
        check_regs();
        go_idle();
    endtask

    // PC, DR and TR are only visible through the bus
    task automatic peek_hidden();
        BUS_SEL = 3'd2; #1; chk_eq("pc", mem_wdata, {4'h0, m_pc});
        BUS_SEL = 3'd3; #1; chk_eq("dr", mem_wdata, m_dr);
        BUS_SEL = 3'd7; #1; chk_eq("tr", mem_wdata, m_tr);
        BUS_SEL = 3'd0;
    endtask

    task automatic set_dr(input logic [15:0] v); apply(3'd6, bm(6), 3'b111, v); endtask
    task automatic set_pc(input logic [15:0] v); apply(3'd6, bm(3), 3'b111, v); endtask
    task automatic set_ar(input logic [15:0] v); apply(3'd6, bm(0), 3'b111, v); endtask
    task automatic set_ac(input logic [15:0] v);
        set_dr(v);
        apply(3'd0, bm(9), 3'b010, 16'h0);
    endtask
    task automatic set_e(input logic v);
        apply(3'd0, bm(19), 3'b111, 16'h0);
        if (v) apply(3'd0, bm(18), 3'b111, 16'h0);
    endtask

    initial begin
        logic [19:0] en;
        go_idle();
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_regs();

        // Asynchronous reset mid-cycle with everything loaded
        apply(3'd6, bm(0) | bm(3) | bm(12) | bm(13), 3'b111, 16'hA5C3);
        set_dr(16'h1234);
        set_ac(16'h1234);
        chk_eq("pre_rst_ac", AC_OUT, 16'h1234);
        CTRL = mk_ctrl(bm(16), 3'b111);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_eq("rst_ac", AC_OUT, 16'h0);
        chk_eq("rst_z",  Z, 1'b1);
        chk_eq("rst_n",  N, 1'b0);
        chk_eq("rst_e",  E_OUT, 1'b0);
        chk_eq("rst_ir", IR, 16'h0);
        chk_eq("rst_ar", mem_addr, 12'h0);
        chk_eq("rst_we", mem_we, 1'b0);
        go_idle();
        peek_hidden();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch
        set_pc(16'h0005);
        apply(3'd2, bm(0), 3'b111, 16'h0);
        chk_eq("fetch_ar", mem_addr, 12'h005);
        apply(3'd6, bm(12) | bm(4), 3'b111, 16'h7800);
        chk_eq("fetch_ir", IR, 16'h7800);
        BUS_SEL = 3'd2; #1; chk_eq("fetch_pc", mem_wdata, 16'h0006); BUS_SEL = 3'd0;

        // ADD with signed overflow
        set_ac(16'h7FFF); set_dr(16'h0001); set_e(1'b0);
        apply(3'd0, bm(9), 3'b000, 16'h0);
        chk_eq("addv_ac", AC_OUT, 16'h8000);
        chk_eq("addv_co", CO, 1'b0);
        chk_eq("addv_ovf", OVF, 1'b1);
        chk_eq("addv_e", E_OUT, 1'b0);
        chk_eq("addv_n", N, 1'b1);

        // ADD with carry
        set_ac(16'hFFFF); set_dr(16'h0001);
        apply(3'd0, bm(9), 3'b000, 16'h0);
        chk_eq("addc_ac", AC_OUT, 16'h0000);
        chk_eq("addc_co", CO, 1'b1);
        chk_eq("addc_e", E_OUT, 1'b1);
        chk_eq("addc_z", Z, 1'b1);

        // Circulate left then right
        set_ac(16'h8001); set_e(1'b0);
        apply(3'd0, bm(9), 3'b100, 16'h0);
        chk_eq("cil_ac", AC_OUT, 16'h0002);
        chk_eq("cil_e", E_OUT, 1'b1);
        apply(3'd0, bm(9), 3'b101, 16'h0);
        chk_eq("cir_ac", AC_OUT, 16'h8001);
        chk_eq("cir_e", E_OUT, 1'b0);

        // Priorities and wrap
        set_ac(16'h0055);
        apply(3'd0, bm(11) | bm(9) | bm(10), 3'b010, 16'h0);
        chk_eq("ac_clr_pri", AC_OUT, 16'h0);
        set_pc(16'hFFFF);
        apply(3'd0, bm(4), 3'b111, 16'h0);
        BUS_SEL = 3'd2; #1; chk_eq("pc_wrap", mem_wdata, 16'h0000); BUS_SEL = 3'd0;
        set_e(1'b1);
        apply(3'd0, bm(19) | bm(18), 3'b111, 16'h0);
        chk_eq("e_clr_pri", E_OUT, 1'b0);

        // Memory write port
        set_ac(16'hBEEF); set_ar(16'h00A0);
        BUS_SEL = 3'd5;
        CTRL    = mk_ctrl(bm(16), 3'b111);
        #2;
        chk_eq("mw_we", mem_we, 1'b1);
        chk_eq("mw_addr", mem_addr, 12'h0A0);
        chk_eq("mw_data", mem_wdata, 16'hBEEF);
        @(posedge clk); #1;
        go_idle();

        // Randomized control vectors
        for (int i = 0; i < 400; i++) begin
            en = 20'($urandom & $urandom);
            if (en[9]) en[11] = 1'b0;
            apply(3'($urandom_range(0, 7)), en, 3'($urandom_range(0, 7)), 16'($urandom));
            if (i % 8 == 0) peek_hidden();
            if (i == 200) begin
                #3 rst_n = 1'b0;
                model_reset();
                #1 check_regs();
                peek_hidden();
                #1 rst_n = 1'b1;
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
